// File: rtl/hue_fade_pkg.sv
// Shared types for the hue fader: channel ramp modes, hue segments and the
// segment-to-mode table.
package hue_fade_pkg;

    typedef enum logic [1:0] {HOLD_HIGH, HOLD_LOW, RAMP_UP, RAMP_DOWN} ch_mode_t;
    typedef enum logic [2:0] {SEG0, SEG1, SEG2, SEG3, SEG4, SEG5} seg_t;

    localparam int NUM_SEG = 6;

    typedef struct packed {
        ch_mode_t b;
        ch_mode_t g;
        ch_mode_t r;
    } seg_modes_t;

    // Mode names describe the forward direction; reverse swaps the ramp formulas.
    function automatic seg_modes_t seg_modes(input seg_t seg);
        seg_modes_t m;
        case (seg)
            SEG0:    m = '{b: HOLD_LOW,  g: RAMP_UP,   r: HOLD_HIGH};
            SEG1:    m = '{b: HOLD_LOW,  g: HOLD_HIGH, r: RAMP_DOWN};
            SEG2:    m = '{b: RAMP_UP,   g: HOLD_HIGH, r: HOLD_LOW};
            SEG3:    m = '{b: HOLD_HIGH, g: RAMP_DOWN, r: HOLD_LOW};
            SEG4:    m = '{b: HOLD_HIGH, g: HOLD_LOW,  r: RAMP_UP};
            SEG5:    m = '{b: RAMP_DOWN, g: HOLD_LOW,  r: HOLD_HIGH};
            default: m = '{b: HOLD_LOW,  g: HOLD_LOW,  r: HOLD_LOW};
        endcase
        return m;
    endfunction

    function automatic seg_t seg_step(input seg_t seg, input logic rev);
        seg_t nxt;
        if (rev) nxt = (seg == SEG0) ? SEG5 : seg_t'(seg - 3'd1);
        else     nxt = (seg == SEG5) ? SEG0 : seg_t'(seg + 3'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/hue_fade_pwm_channel.sv
// One PWM pad: latches its duty at the period boundary and drives a registered,
// polarity-adjusted pad from the shared counter.
module pwm_channel #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int DW = $clog2(PWM_INTERVAL + 1),
    localparam int CW = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] pwm_cnt,
    input  logic          period_end,
    input  logic [DW-1:0] duty_next,
    output logic          pad
);

    logic [DW-1:0] duty_reg;

    // duty_reg only moves on the last count, so every period uses one duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_reg <= '0;
            pad      <= ACTIVE_LOW;
        end else begin
            if (period_end) duty_reg <= duty_next;
            pad <= (DW'(pwm_cnt) < duty_reg) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/hue_fade_pwm.sv
// Three-channel hue-wheel fader with PWM pads. Optional HUE_FADE_DIM_EN adds a
// dim[1:0] input that right-shifts every duty.
module hue_fade_pwm
    import hue_fade_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP         = 12,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
`ifdef HUE_FADE_DIM_EN
    input  logic [1:0] dim,
`endif
    output logic [2:0] pwm_out,
    output logic [2:0] segment,
    output logic       cycle_done
);

    localparam int DW = $clog2(PWM_INTERVAL + 1);
    localparam int CW = $clog2(PWM_INTERVAL);
    localparam logic [CW-1:0] CNT_MAX = CW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] FULL    = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   STEP_W  = (DW+1)'(STEP);
    localparam logic [DW:0]   LIMIT_W = (DW+1)'(PWM_INTERVAL);

    if (STEP < 1 || STEP > PWM_INTERVAL) begin : g_step_chk
        $error("hue_fade_pwm: STEP must be within 1..PWM_INTERVAL");
    end

    logic [CW-1:0]        pwm_cnt;
    logic                 period_end;
    seg_t                 seg, seg_next;
    logic [DW-1:0]        ramp, ramp_next;
    logic [DW:0]          ramp_sum;
    logic                 done_next;
    seg_modes_t           modes;
    logic [2:0][DW-1:0]   duty, duty_next;

    function automatic logic [DW-1:0] duty_of(input ch_mode_t m, input logic [DW-1:0] r,
                                              input logic rev);
        logic [DW-1:0] d;
        case (m)
            HOLD_HIGH: d = FULL;
            RAMP_UP:   d = rev ? FULL - r : r;
            RAMP_DOWN: d = rev ? r : FULL - r;
            default:   d = '0;
        endcase
        return d;
    endfunction

    assign period_end = (pwm_cnt == CNT_MAX);
    assign ramp_sum   = {1'b0, ramp} + STEP_W;
    assign segment    = seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= period_end ? '0 : pwm_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG0;
            ramp       <= '0;
            cycle_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            ramp       <= ramp_next;
            cycle_done <= done_next;
        end
    end

    // en and dir only matter on the last count of a period.
    always_comb begin
        seg_next  = seg;
        ramp_next = ramp;
        done_next = 1'b0;
        if (period_end && en) begin
            if (ramp_sum >= LIMIT_W) begin
                ramp_next = '0;
                seg_next  = seg_step(seg, dir);
                done_next = dir ? (seg == SEG0) : (seg == SEG5);
            end else begin
                ramp_next = ramp_sum[DW-1:0];
            end
        end
    end

    always_comb begin
        modes   = seg_modes(seg);
        duty[0] = duty_of(modes.r, ramp, dir);
        duty[1] = duty_of(modes.g, ramp, dir);
        duty[2] = duty_of(modes.b, ramp, dir);
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
`ifdef HUE_FADE_DIM_EN
        assign duty_next[i] = duty[i] >> dim;
`else
        assign duty_next[i] = duty[i];
`endif
        pwm_channel #(
            .PWM_INTERVAL (PWM_INTERVAL),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .pwm_cnt    (pwm_cnt),
            .period_end (period_end),
            .duty_next  (duty_next[i]),
            .pad        (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_hue_fade_pwm.sv
// Directed bench for hue_fade_pwm at PWM_INTERVAL=8, STEP=4, active-low pads:
// per-period active-clock counts, segment and cycle_done against a hand table.
module tb_hue_fade_pwm;

    localparam int N    = 8;
    localparam int STP  = 4;
    localparam int NVEC = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] pwm_out;
    logic [2:0] segment;
    logic       cycle_done;
`ifdef HUE_FADE_DIM_EN
    logic [1:0] dim = 2'd0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic en;
        logic dir;
        int   r;
        int   g;
        int   b;
        int   seg;
        int   done;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    hue_fade_pwm #(
        .PWM_INTERVAL (N),
        .STEP         (STP),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
`ifdef HUE_FADE_DIM_EN
        .dim        (dim),
`endif
        .pwm_out    (pwm_out),
        .segment    (segment),
        .cycle_done (cycle_done)
    );

    function automatic vec_t mk(input logic e, input logic d, input int r, input int g,
                                input int b, input int s, input int dn);
        vec_t v;
        v.en = e; v.dir = d; v.r = r; v.g = g; v.b = b; v.seg = s; v.done = dn;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Hold rst_n low for two clocks, check reset outputs, release at a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        dir   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.pwm_out", int'(pwm_out), 3'b111);
        check("rst.segment", int'(segment), 0);
        check("rst.done",    int'(cycle_done), 0);
        rst_n = 1'b1;
    endtask

    // One PWM period: count active (low) clocks per pad and cycle_done pulses;
    // segment is read right after the period boundary that closes the window.
    task automatic run_window(input int idx);
        int cr = 0;
        int cg = 0;
        int cb = 0;
        int cd = 0;
        en  = vecs[idx].en;
        dir = vecs[idx].dir;
        repeat (N) begin
            @(posedge clk);
            #1;
            cr += int'(!pwm_out[0]);
            cg += int'(!pwm_out[1]);
            cb += int'(!pwm_out[2]);
            cd += int'(cycle_done);
        end
        check($sformatf("w%0d.r_on", idx), cr, vecs[idx].r);
        check($sformatf("w%0d.g_on", idx), cg, vecs[idx].g);
        check($sformatf("w%0d.b_on", idx), cb, vecs[idx].b);
        check($sformatf("w%0d.seg",  idx), int'(segment), vecs[idx].seg);
        check($sformatf("w%0d.done", idx), cd, vecs[idx].done);
    endtask

    initial begin
        //                en    dir   R  G  B  seg done
        vecs[0]  = mk(1'b1, 1'b0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1'b1, 1'b0, 8, 0, 0, 1, 0);
        vecs[2]  = mk(1'b1, 1'b0, 8, 4, 0, 1, 0);
        vecs[3]  = mk(1'b1, 1'b0, 8, 8, 0, 2, 0);
        vecs[4]  = mk(1'b1, 1'b0, 4, 8, 0, 2, 0);
        vecs[5]  = mk(1'b1, 1'b0, 0, 8, 0, 3, 0);
        vecs[6]  = mk(1'b1, 1'b0, 0, 8, 4, 3, 0);
        vecs[7]  = mk(1'b1, 1'b0, 0, 8, 8, 4, 0);
        vecs[8]  = mk(1'b1, 1'b0, 0, 4, 8, 4, 0);
        vecs[9]  = mk(1'b1, 1'b0, 0, 0, 8, 5, 0);
        vecs[10] = mk(1'b1, 1'b0, 4, 0, 8, 5, 0);
        vecs[11] = mk(1'b1, 1'b0, 8, 0, 8, 0, 1);
        vecs[12] = mk(1'b1, 1'b0, 8, 0, 4, 0, 0);
        vecs[13] = mk(1'b1, 1'b0, 8, 0, 0, 1, 0);
        vecs[14] = mk(1'b1, 1'b0, 8, 4, 0, 1, 0);
        vecs[15] = mk(1'b1, 1'b0, 8, 8, 0, 2, 0);
        vecs[16] = mk(1'b1, 1'b0, 4, 8, 0, 2, 0);
        // pause five periods at segment 2, ramp 4
        vecs[17] = mk(1'b0, 1'b0, 0, 8, 0, 2, 0);
        vecs[18] = mk(1'b0, 1'b0, 0, 8, 4, 2, 0);
        vecs[19] = mk(1'b0, 1'b0, 0, 8, 4, 2, 0);
        vecs[20] = mk(1'b0, 1'b0, 0, 8, 4, 2, 0);
        vecs[21] = mk(1'b0, 1'b0, 0, 8, 4, 2, 0);
        // reverse from segment 2, ramp 4
        vecs[22] = mk(1'b1, 1'b1, 0, 8, 4, 1, 0);
        vecs[23] = mk(1'b1, 1'b1, 0, 8, 4, 1, 0);
        vecs[24] = mk(1'b1, 1'b1, 0, 8, 0, 0, 0);
        vecs[25] = mk(1'b1, 1'b1, 4, 8, 0, 0, 0);
        vecs[26] = mk(1'b1, 1'b1, 8, 8, 0, 5, 1);
        vecs[27] = mk(1'b1, 1'b1, 8, 4, 0, 5, 0);
        vecs[28] = mk(1'b1, 1'b1, 8, 0, 0, 4, 0);
        vecs[29] = mk(1'b1, 1'b1, 8, 0, 4, 4, 0);

        do_reset();
        for (int i = 0; i < NVEC; i++) run_window(i);

        // Async reset mid-period while in segment 3, G active.
        do_reset();
        for (int i = 0; i < 6; i++) run_window(i);
        #3;
        check("pre_rst.segment", int'(segment), 3);
        check("pre_rst.pwm_out", int'(pwm_out), 3'b101);
        rst_n = 1'b0;
        #1;
        check("async_rst.pwm_out", int'(pwm_out), 3'b111);
        check("async_rst.segment", int'(segment), 0);
        check("async_rst.done",    int'(cycle_done), 0);

`ifdef HUE_FADE_DIM_EN
        // dim=2 at segment 0, ramp 0: R duty 8 >> 2 = 2 clocks per period.
        do_reset();
        en  = 1'b0;
        dim = 2'd2;
        repeat (N) @(posedge clk);
        begin
            int cr = 0;
            int cg = 0;
            repeat (N) begin
                @(posedge clk);
                #1;
                cr += int'(!pwm_out[0]);
                cg += int'(!pwm_out[1]);
            end
            check("dim.r_on", cr, 2);
            check("dim.g_on", cg, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
